// File: rtl/diffe_shared_key.sv
// diffe_shared_key: responder-side Diffie-Hellman completion.
// Computes KEY = PUB^X mod P by MSB-first square-and-multiply. Each modular
// product is formed by a bit-serial interleaved shift-add multiplier that
// takes WIDTH cycles.
//
// Build option: define DIFFE_CONST_TIME_EN to run the multiply step for
// every exponent bit, discarding it for 0 bits. This gives a latency that
// does not depend on X. When it is undefined, the multiply step is skipped
// for 0 bits, so latency depends on popcount(X).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for ST; latches operands and screens them for errors
// SQR   | acc = acc*acc mod P, one multiplier bit per cycle
// MUL   | product = acc*base mod P, committed only if the exponent bit is 1
// FIN   | publish KEY/ERR; DONE pulses on the edge that leaves FIN

module diffe_shared_key #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ST,
  input  logic [WIDTH-1:0] PUB,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] P,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic [WIDTH-1:0] KEY
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SQR, S_MUL, S_FIN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_base;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH:0]   r_r;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    r_bit;
  logic             r_err_pend;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [WIDTH-1:0] r_key;

  logic             w_op_err;
  logic             w_cnt_tc;
  logic             w_bit_tc;
  logic             w_xbit;
  logic             w_abit;
  logic             w_go_mul;
  logic             w_bit_end;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_p_ext;
  logic [WIDTH:0]   w_dbl;
  logic [WIDTH:0]   w_dbl_red;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_sum_red;

  // P < 2 is the same as every bit above bit 0 being clear.
  assign w_op_err = (P[WIDTH-1:1] == '0) || (PUB >= P);
  assign w_cnt_tc = (r_cnt == '0);
  assign w_bit_tc = (r_bit == '0);
  assign w_xbit   = r_x[r_bit];
  assign w_abit   = r_acc[r_cnt];

`ifdef DIFFE_CONST_TIME_EN
  assign w_go_mul = 1'b1;
`else
  assign w_go_mul = w_xbit;
`endif

  // Squaring multiplies acc by itself; the multiply step uses the latched base.
  assign w_b = (r_state == S_MUL) ? r_base : r_acc;

  // One shift-add step. R < P < 2^WIDTH, so 2R and R+b both fit in WIDTH+1
  // bits, and a single conditional subtraction brings each back below P.
  assign w_p_ext   = {1'b0, r_p};
  assign w_dbl     = r_r + r_r;
  assign w_dbl_red = (w_dbl >= w_p_ext) ? (w_dbl - w_p_ext) : w_dbl;
  assign w_sum     = w_dbl_red + (w_abit ? {1'b0, w_b} : '0);
  assign w_sum_red = (w_sum >= w_p_ext) ? (w_sum - w_p_ext) : w_sum;

  // A bit ends after its last product: after SQR when the multiply step is
  // skipped, or after MUL.
  assign w_bit_end = w_cnt_tc &&
                     (((r_state == S_SQR) && !w_go_mul) || (r_state == S_MUL));

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic; the bit-end decision is folded into the SQR/MUL exits.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (ST) w_state_nxt = w_op_err ? S_FIN : S_SQR;
      S_SQR: begin
        if (w_cnt_tc) begin
          if (w_go_mul)      w_state_nxt = S_MUL;
          else if (w_bit_tc) w_state_nxt = S_FIN;
        end
      end
      S_MUL:   if (w_cnt_tc) w_state_nxt = w_bit_tc ? S_FIN : S_SQR;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand latches, multiplier datapath and registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_base     <= '0;
      r_x        <= '0;
      r_p        <= '0;
      r_acc      <= '0;
      r_r        <= '0;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_err_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_key      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ST) begin
            r_base     <= PUB;
            r_x        <= X;
            r_p        <= P;
            r_key      <= '0;
            r_err      <= 1'b0;
            r_err_pend <= w_op_err;
            r_acc      <= w_op_err ? '0 : WIDTH'(1);
            r_bit      <= CW'(WIDTH - 1);
            r_cnt      <= CW'(WIDTH - 1);
            r_r        <= '0;
            r_busy     <= !w_op_err;
          end
        end
        S_SQR, S_MUL: begin
          if (w_cnt_tc) begin
            r_r   <= '0;
            r_cnt <= CW'(WIDTH - 1);
            // A product computed for a 0 exponent bit is dropped here.
            if ((r_state == S_SQR) || w_xbit) r_acc <= w_sum_red[WIDTH-1:0];
            if (w_bit_end && !w_bit_tc) r_bit <= r_bit - CW'(1);
          end else begin
            r_r   <= w_sum_red;
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_FIN: begin
          r_key  <= r_err_pend ? '0 : r_acc;
          r_err  <= r_err_pend;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign BUSY = r_busy;
  assign DONE = r_done;
  assign ERR  = r_err;
  assign KEY  = r_key;

endmodule

// File: doc/diffe_shared_key.md
# diffe_shared_key

Responder-side completion of the Diffie-Hellman exchange. It accepts the peer's public value, the local private exponent and the shared modulus, and computes the shared secret KEY = PUB^X mod P by iterative square-and-multiply over a bit-serial modular multiplier. It sits beside `Diffe_TOP`: `Diffe_TOP` produces the local public value, and this block consumes the value returned by the other party.

## Interface
- WIDTH, 32: operand and key width in bits.
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset, asynchronous, active-low.
- ST  input  1  start request; sampled only in IDLE.
- PUB  input  WIDTH  peer public value; must satisfy PUB < P.
- X  input  WIDTH  local private exponent.
- P  input  WIDTH  modulus; must satisfy P ≥ 2.
- BUSY  output  1  high while a computation is in progress. Reset value 0.
- DONE  output  1  one-cycle pulse when KEY and ERR are valid. Reset value 0.
- ERR  output  1  operand error for the last request; held until the next accepted ST. Reset value 0.
- KEY  output  WIDTH  shared secret; held until the next accepted ST. Reset value 0.

## Operation
- States: IDLE, SQR, MUL, FIN.
- **IDLE, ST=1:**
  - Latch PUB, X and P into internal registers. Later input changes have no effect.
  - Clear KEY and ERR.
  - If P < 2 or PUB ≥ P: go to FIN with ERR=1 and the result forced to 0.
  - Otherwise: set acc=1, bit index=WIDTH-1, BUSY=1, and go to SQR.
- **SQR:** acc = acc·acc mod P. Takes WIDTH cycles. Then go to MUL if the current exponent bit is 1, or if DIFFE_CONST_TIME_EN is defined. Otherwise go to the bit-end step.
- **MUL:** product = acc·base mod P. Takes WIDTH cycles. The product is committed to acc only when the current exponent bit is 1.
- **Bit end:** if bit index = 0, go to FIN. Otherwise decrement the bit index and go to SQR.
- **FIN:** KEY = acc (or 0 on error), DONE=1 for this cycle only, BUSY=0, return to IDLE.
- **Modular multiply (a·b mod P)** uses interleaved shift-add, MSB of a first, one bit per cycle:
  - R = 2R; if R ≥ P then R = R − P.
  - If a[i]=1: R = R + b; if R ≥ P then R = R − P.
  - R is WIDTH+1 bits wide, so no overflow occurs for any P up to 2^WIDTH−1.
  - Both operands are always < P, so one conditional subtraction per step is sufficient.
- **Boundary cases:**
  - X=0 gives KEY=1.
  - PUB=0 with X≠0 gives KEY=0.
  - ST while BUSY is ignored and does not queue.
  - ST held high across FIN starts a new request in the IDLE cycle that follows.
- **Reset mid-operation:** all state returns immediately to IDLE. KEY, DONE, BUSY and ERR go to 0. No DONE pulse is issued for the aborted request.

## Timing
- ST is sampled at edge k. BUSY is high after edge k and through the cycle before DONE.
- Valid request, constant-time build: DONE is high in the cycle after edge k + 2·WIDTH² + 1. For WIDTH=32 this is 2049.
- Valid request, variable-time build: DONE at k + WIDTH·(WIDTH + popcount(X)) + 1.
- Error request: DONE at k + 1, with BUSY remaining 0.
- KEY and ERR change only at the edge where DONE rises, and at accepted ST (cleared).
- The earliest next ST is sampled in the cycle after DONE.

## Configuration
- **DIFFE_CONST_TIME_EN defined:**
  - MUL runs for every exponent bit; the product is discarded when the bit is 0.
  - Latency is fixed at 2·WIDTH² + 1, independent of X, which closes the timing side channel.
- **DIFFE_CONST_TIME_EN undefined:**
  - MUL is skipped for 0 bits.
  - Latency depends on popcount(X), giving lower average latency.
- KEY values are identical in both builds.

## Test plan
- P=23, PUB=8, X=6 → KEY=13, ERR=0. DONE after 2049 cycles (const) or 1089 cycles (variable); exactly one DONE pulse.
- P=23, PUB=5, X=6 → KEY=8. Then P=23, PUB=5, X=0 → KEY=1.
- P=5, PUB=17 → ERR=1, KEY=0, DONE at k+1, BUSY never high. P=1, PUB=0 → ERR=1.
- P=0xFFFFFFFB, PUB=0xFFFFFFFA (= −1 mod P), X=3 → KEY=0xFFFFFFFA, with no overflow in the intermediates.
- Pulse ST again 100 cycles into a computation with different operands → ignored, and the original KEY is produced. Changing PUB, X or P during BUSY has no effect.
- Drive RST low 500 cycles into a computation → outputs go to 0 immediately and no DONE is issued. After release, a new request P=23, PUB=8, X=6 → KEY=13.
